flow_led_key_ctrl: RTL and testbench

- Upstream control stage for the flow-LED display block.
- Converts two raw, bouncing, active-low push buttons into the stable level controls the display consumes: flow_led_stop (pause) and sw_change (counter-mode / shift-mode select).
- Each confirmed press toggles its control and emits a one-cycle press strobe.
- Runs entirely in the 50 MHz system clock domain; no derived clocks.

---
 rtl/flow_led_pkg.sv | 15 +
 rtl/key_debounce.sv | 84 ++++++++
 rtl/flow_led_key_ctrl.sv | 61 ++++++
 tb/tb_flow_led_key_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/flow_led_pkg.sv
// Shared definitions for the flow-LED control path: key FSM states and clock/debounce constants.
package flow_led_pkg;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned CNT_W_DEFAULT      = 20;

    typedef enum logic [1:0] {
        REL       = 2'd0,
        PRESS_CHK = 2'd1,
        PRS       = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button path: two-flop synchroniser, four-state debounce FSM and qualification counter.
// Emits a registered one-cycle strobe on each accepted press plus the registered stable level.
module key_debounce
    import flow_led_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             level_q, level_d;
    logic             ks;

    // sync_q[1] is the synchronised pin level (0 = pressed)
    assign ks = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            state_q <= REL;
            cnt_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            REL: begin
                if (!ks) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (ks) begin
                    state_d = REL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRS;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRS: begin
                if (ks) state_d = REL_CHK;
            end
            REL_CHK: begin
                if (!ks) begin
                    state_d = PRS;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = REL;
        endcase
        // every qualification window starts from zero
        if (state_d != state_q) cnt_d = '0;
        level_d = (state_d == PRS) || (state_d == REL_CHK);
    end

    assign press_o = press_q;
    assign level_o = level_q;

endmodule

// File: rtl/flow_led_key_ctrl.sv
// Turns the raw pause and mode buttons into toggled level controls for the flow-LED display,
// with a one-cycle strobe per accepted press. Single 50 MHz clock domain.
module flow_led_key_ctrl
    import flow_led_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key_stop_n,
    input  logic key_mode_n,
    output logic flow_led_stop,
    output logic sw_change,
    output logic stop_press,
    output logic mode_press
);

    logic stop_strb, mode_strb;
    logic stop_level_unused, mode_level_unused;
    logic flow_stop_q, sw_change_q;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_key_stop (
        .clk_i   (clk_50m),
        .rst_n_i (rst_n),
        .key_n_i (key_stop_n),
        .press_o (stop_strb),
        .level_o (stop_level_unused)
    );

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_key_mode (
        .clk_i   (clk_50m),
        .rst_n_i (rst_n),
        .key_n_i (key_mode_n),
        .press_o (mode_strb),
        .level_o (mode_level_unused)
    );

    // Keys are independent: each strobe flips only its own level
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            flow_stop_q <= 1'b0;
            sw_change_q <= 1'b0;
        end else begin
            flow_stop_q <= flow_stop_q ^ stop_strb;
            sw_change_q <= sw_change_q ^ mode_strb;
        end
    end

    assign flow_led_stop = flow_stop_q;
    assign sw_change     = sw_change_q;
    assign stop_press    = stop_strb;
    assign mode_press    = mode_strb;

endmodule

// File: tb/tb_flow_led_key_ctrl.sv
// Bench for flow_led_key_ctrl with a short debounce window: segment table, reset sequence
// and randomized pin activity, all compared against a run-length reference model.
module tb_flow_led_key_ctrl;

    localparam int unsigned DEB = 16;
    // first sampling edge of a pin change counts as step 1
    localparam int          LAT = DEB + 3;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    logic key_stop_n = 1'b0;
    logic key_mode_n = 1'b0;
    logic flow_led_stop, sw_change, stop_press, mode_press;

    flow_led_key_ctrl #(
        .DEB_CYCLES (DEB),
        .CNT_W      (5)
    ) dut (
        .clk_50m       (clk_50m),
        .rst_n         (rst_n),
        .key_stop_n    (key_stop_n),
        .key_mode_n    (key_mode_n),
        .flow_led_stop (flow_led_stop),
        .sw_change     (sw_change),
        .stop_press    (stop_press),
        .mode_press    (mode_press)
    );

    always #10 clk_50m = ~clk_50m;

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the synchronised pin has disagreed with
    // the accepted level for DEB+1 consecutive edges; the pin reaches the decision two edges late.
    bit m_h1 [2];
    bit m_h2 [2];
    bit m_acc[2];
    bit m_strb[2];
    bit m_lvl[2];
    int m_run[2];

    function automatic void model_edge(input bit rstn, input bit pin0, input bit pin1);
        for (int k = 0; k < 2; k++) begin
            bit x;
            bit ns;
            bit pin;
            pin = (k == 0) ? pin0 : pin1;
            if (!rstn) begin
                m_h1[k] = 1'b1; m_h2[k] = 1'b1; m_acc[k] = 1'b1;
                m_strb[k] = 1'b0; m_lvl[k] = 1'b0; m_run[k] = 0;
            end else begin
                x  = m_h2[k];
                ns = 1'b0;
                if (x != m_acc[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == int'(DEB) + 1) begin
                        m_acc[k] = x;
                        m_run[k] = 0;
                        ns = (x == 1'b0);
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_lvl[k]  = m_lvl[k] ^ m_strb[k];
                m_h2[k]   = m_h1[k];
                m_h1[k]   = pin;
                m_strb[k] = ns;
            end
        end
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    int n_stop, n_mode, first_stop, first_mode, seg_step;

    task automatic step();
        @(posedge clk_50m);
        model_edge(rst_n, key_stop_n, key_mode_n);
        #1;
        chk_bit("stop_press", stop_press, m_strb[0]);
        chk_bit("mode_press", mode_press, m_strb[1]);
        chk_bit("flow_led_stop", flow_led_stop, m_lvl[0]);
        chk_bit("sw_change", sw_change, m_lvl[1]);
        seg_step++;
        if (stop_press === 1'b1) begin
            n_stop++;
            if (first_stop == 0) first_stop = seg_step;
        end
        if (mode_press === 1'b1) begin
            n_mode++;
            if (first_mode == 0) first_mode = seg_step;
        end
    endtask

    task automatic seg_clear();
        n_stop = 0; n_mode = 0; first_stop = 0; first_mode = 0; seg_step = 0;
    endtask

    typedef struct {
        bit stop_n;
        bit mode_n;
        int len;
        int n_stop;
        int n_mode;
        int first_stop;
        int first_mode;
        bit flow;
        bit sw;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, bit m, int len, int ns, int nm, int fs, int fm, bit fl, bit sw);
        vec_t v;
        v.stop_n = s; v.mode_n = m; v.len = len;
        v.n_stop = ns; v.n_mode = nm; v.first_stop = fs; v.first_mode = fm;
        v.flow = fl; v.sw = sw;
        return v;
    endfunction

    initial begin
        // segments start from the state left by the reset-with-keys-held sequence
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   1, 1));  // release both: no strobe
        tbl.push_back(mk(0, 1, 40, 1, 0, LAT, 0,   0, 1));  // clean pause press
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   0, 1));  // release: no second strobe
        tbl.push_back(mk(0, 1, 40, 1, 0, LAT, 0,   1, 1));  // second press toggles back
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   1, 1));
        tbl.push_back(mk(0, 1, 15, 0, 0, 0,   0,   1, 1));  // short glitch rejected
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   1, 1));
        tbl.push_back(mk(0, 0, 30, 1, 1, LAT, LAT, 0, 0));  // simultaneous presses
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   0, 0));
        for (int i = 0; i < 12; i++)                         // mode bounce, 5-cycle phases
            tbl.push_back(mk(1, (i % 2 == 0) ? 1'b0 : 1'b1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 30, 0, 1, 0,   LAT, 0, 1));  // steady low after bounce
        tbl.push_back(mk(1, 1, 10, 0, 0, 0,   0,   0, 1));  // release bounce while held
        tbl.push_back(mk(1, 0, 30, 0, 0, 0,   0,   0, 1));
        tbl.push_back(mk(1, 1, 40, 0, 0, 0,   0,   0, 1));

        // Reset held with both keys pressed
        rst_n = 1'b0; key_stop_n = 1'b0; key_mode_n = 1'b0;
        seg_clear();
        for (int i = 0; i < 3; i++) step();
        chk_bit("rst_flow_led_stop", flow_led_stop, 1'b0);
        chk_bit("rst_sw_change", sw_change, 1'b0);
        chk_bit("rst_stop_press", stop_press, 1'b0);
        chk_bit("rst_mode_press", mode_press, 1'b0);

        // Release reset with keys still held: exactly one accepted press each
        rst_n = 1'b1;
        seg_clear();
        for (int i = 0; i < 40; i++) step();
        chk_int("rst_held_stop_count", n_stop, 1);
        chk_int("rst_held_mode_count", n_mode, 1);
        chk_int("rst_held_stop_latency", first_stop, LAT);
        chk_int("rst_held_mode_latency", first_mode, LAT);
        chk_bit("rst_held_flow_led_stop", flow_led_stop, 1'b1);
        chk_bit("rst_held_sw_change", sw_change, 1'b1);

        foreach (tbl[j]) begin
            key_stop_n = tbl[j].stop_n;
            key_mode_n = tbl[j].mode_n;
            seg_clear();
            for (int i = 0; i < tbl[j].len; i++) step();
            chk_int($sformatf("seg%0d_stop_count", j), n_stop, tbl[j].n_stop);
            chk_int($sformatf("seg%0d_mode_count", j), n_mode, tbl[j].n_mode);
            chk_int($sformatf("seg%0d_stop_first", j), first_stop, tbl[j].first_stop);
            chk_int($sformatf("seg%0d_mode_first", j), first_mode, tbl[j].first_mode);
            chk_bit($sformatf("seg%0d_flow_led_stop", j), flow_led_stop, tbl[j].flow);
            chk_bit($sformatf("seg%0d_sw_change", j), sw_change, tbl[j].sw);
        end

        // Randomized pin activity with occasional resets, checked cycle by cycle
        for (int b = 0; b < 200; b++) begin
            int len;
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                len = int'($urandom_range(1, 3));
            end else begin
                rst_n = 1'b1;
                key_stop_n = 1'($urandom_range(0, 1));
                key_mode_n = 1'($urandom_range(0, 1));
                len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12))
                                                  : int'($urandom_range(14, 40));
            end
            seg_clear();
            for (int i = 0; i < len; i++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
